fpga_soc_reset_sequencer: RTL and testbench

- Board-level reset and boot sequencer between the raw FPGA board pins and the SoC top.
- Synchronises the reset button and the clock-wizard lock, and holds the SoC in reset until the clock is stable plus a fixed hold time.
- Latches the boot straps (boot_select, execute_from_flash) at reset release.
- Captures the SoC exit status and drives the debug LEDs.
- Instantiated once in each FPGA board wrapper, in the generated-clock domain.

---
 rtl/fpga_soc_reset_sequencer.sv | 173 +++++++++++++++++
 tb/tb_fpga_soc_reset_sequencer.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpga_soc_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fpga_soc_reset_sequencer
// Purpose  : Board reset/boot sequencer: syncs button and clock lock, holds the
//            SoC in reset, latches boot straps and captures the SoC exit status.
// Option   : FPGA_RST_DEBOUNCE_EN enables the reset-button debouncer.
// Revision : 1.0 - initial release
// ============================================================================
module fpga_soc_reset_sequencer #(
    parameter int HOLD_CYCLES          = 64,
    parameter int DEBOUNCE_CYCLES      = 65536,
    parameter int CLK_LED_COUNT_LENGTH = 27
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       btn_rst_i,
    input  logic       clk_locked_i,
    input  logic       boot_select_i,
    input  logic       execute_from_flash_i,
    input  logic       exit_valid_i,
    input  logic       exit_value_i,
    output logic       soc_rst_no,
    output logic       boot_select_o,
    output logic       execute_from_flash_o,
    output logic       exit_done_o,
    output logic       exit_ok_o,
    output logic [2:0] state_o,
    output logic       rst_led_o,
    output logic       clk_led_o
);

    typedef enum logic [2:0] {
        ST_RESET     = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_HOLD      = 3'd2,
        ST_RUN       = 3'd3,
        ST_DONE      = 3'd4
    } state_t;

    localparam logic [15:0] c_hold_last = 16'(HOLD_CYCLES - 1);

    // Out-of-range parameters leave this marker block in the elaborated hierarchy.
    if (HOLD_CYCLES < 2 || HOLD_CYCLES > 65535 ||
        DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 1048576) begin : g_param_out_of_range
    end

    state_t                          r_state;
    logic   [15:0]                   r_hold_cnt;
    logic                            r_soc_rst_n;
    logic                            r_boot_select;
    logic                            r_exec_flash;
    logic                            r_exit_done;
    logic                            r_exit_ok;
    logic   [CLK_LED_COUNT_LENGTH-1:0] r_blink_cnt;
    logic   [3:0]                    r_sync_meta;
    logic   [3:0]                    r_sync;
    logic                            w_btn_s;
    logic                            w_lock_s;
    logic                            w_boot_s;
    logic                            w_exec_s;
    logic                            w_btn_req;

    // Bit order: {execute_from_flash, boot_select, clk_locked, btn_rst}
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_sync_meta <= 4'b0000;
            r_sync      <= 4'b0000;
        end else begin
            r_sync_meta <= {execute_from_flash_i, boot_select_i, clk_locked_i, btn_rst_i};
            r_sync      <= r_sync_meta;
        end
    end

    assign w_btn_s  = r_sync[0];
    assign w_lock_s = r_sync[1];
    assign w_boot_s = r_sync[2];
    assign w_exec_s = r_sync[3];

`ifdef FPGA_RST_DEBOUNCE_EN
    localparam logic [19:0] c_db_last = 20'(DEBOUNCE_CYCLES - 1);

    logic [19:0] r_db_cnt;
    logic        r_btn_req;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_db_cnt  <= 20'd0;
            r_btn_req <= 1'b0;
        end else if (w_btn_s == r_btn_req) begin
            r_db_cnt  <= 20'd0;
        end else if (r_db_cnt == c_db_last) begin
            r_btn_req <= w_btn_s;
            r_db_cnt  <= 20'd0;
        end else begin
            r_db_cnt  <= r_db_cnt + 20'd1;
        end
    end

    assign w_btn_req = r_btn_req;
`else
    assign w_btn_req = w_btn_s;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state       <= ST_RESET;
            r_hold_cnt    <= 16'd0;
            r_soc_rst_n   <= 1'b0;
            r_boot_select <= 1'b0;
            r_exec_flash  <= 1'b0;
            r_exit_done   <= 1'b0;
            r_exit_ok     <= 1'b0;
        end else if (r_state != ST_RESET && (!w_lock_s || w_btn_req)) begin
            r_state     <= ST_WAIT_LOCK;
            r_soc_rst_n <= 1'b0;
        end else begin
            case (r_state)
                ST_RESET: begin
                    r_state     <= ST_WAIT_LOCK;
                    r_soc_rst_n <= 1'b0;
                end
                // Reaching here already implies lock present and no button request.
                ST_WAIT_LOCK: begin
                    r_state    <= ST_HOLD;
                    r_hold_cnt <= 16'd0;
                end
                ST_HOLD: begin
                    if (r_hold_cnt == c_hold_last) begin
                        r_boot_select <= w_boot_s;
                        r_exec_flash  <= w_exec_s;
                        r_exit_done   <= 1'b0;
                        r_exit_ok     <= 1'b0;
                        r_state       <= ST_RUN;
                        r_soc_rst_n   <= 1'b1;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 16'd1;
                    end
                end
                ST_RUN: begin
                    if (exit_valid_i) begin
                        r_exit_ok   <= ~exit_value_i;
                        r_exit_done <= 1'b1;
                        r_state     <= ST_DONE;
                    end
                end
                ST_DONE: ;
                default: begin
                    r_state     <= ST_RESET;
                    r_soc_rst_n <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_blink_cnt <= '0;
        end else begin
            r_blink_cnt <= r_blink_cnt + CLK_LED_COUNT_LENGTH'(1);
        end
    end

    assign soc_rst_no           = r_soc_rst_n;
    assign boot_select_o        = r_boot_select;
    assign execute_from_flash_o = r_exec_flash;
    assign exit_done_o          = r_exit_done;
    assign exit_ok_o            = r_exit_ok;
    assign state_o              = r_state;
    assign rst_led_o            = r_soc_rst_n;
    assign clk_led_o            = r_blink_cnt[CLK_LED_COUNT_LENGTH-1];

endmodule
`default_nettype wire

// File: tb/tb_fpga_soc_reset_sequencer.sv
`default_nettype none
// Testbench for fpga_soc_reset_sequencer: directed plus randomized board-pin
// stimulus compared every cycle against a behavioural reference model.
module tb_fpga_soc_reset_sequencer;

    localparam int HOLD = 64;
    localparam int DEB  = 16;
    localparam int LEDW = 4;
`ifdef FPGA_RST_DEBOUNCE_EN
    localparam bit DEB_EN = 1'b1;
`else
    localparam bit DEB_EN = 1'b0;
`endif
    // Edge (counted from the press) at which a button press takes the SoC down.
    localparam int REQ_EDGE = DEB_EN ? (2 + DEB + 1) : 3;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       btn_rst_i;
    logic       clk_locked_i;
    logic       boot_select_i;
    logic       execute_from_flash_i;
    logic       exit_valid_i;
    logic       exit_value_i;
    logic       soc_rst_no;
    logic       boot_select_o;
    logic       execute_from_flash_o;
    logic       exit_done_o;
    logic       exit_ok_o;
    logic [2:0] state_o;
    logic       rst_led_o;
    logic       clk_led_o;

    fpga_soc_reset_sequencer #(
        .HOLD_CYCLES          (HOLD),
        .DEBOUNCE_CYCLES      (DEB),
        .CLK_LED_COUNT_LENGTH (LEDW)
    ) u_dut (
        .clk_i                (clk_i),
        .rst_ni               (rst_ni),
        .btn_rst_i            (btn_rst_i),
        .clk_locked_i         (clk_locked_i),
        .boot_select_i        (boot_select_i),
        .execute_from_flash_i (execute_from_flash_i),
        .exit_valid_i         (exit_valid_i),
        .exit_value_i         (exit_value_i),
        .soc_rst_no           (soc_rst_no),
        .boot_select_o        (boot_select_o),
        .execute_from_flash_o (execute_from_flash_o),
        .exit_done_o          (exit_done_o),
        .exit_ok_o            (exit_ok_o),
        .state_o              (state_o),
        .rst_led_o            (rst_led_o),
        .clk_led_o            (clk_led_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: mode 0..4, HOLD ends at an absolute edge number.
    int     m_mode;
    longint m_edge;
    longint m_run_at;
    bit     m_boot, m_xff, m_done, m_ok, m_btn_req;
    int     m_mismatch;
    bit     q_lock[$];
    bit     q_btn[$];
    bit     q_boot[$];
    bit     q_xff[$];

    function automatic void model_reset();
        m_mode     = 0;
        m_edge     = 0;
        m_run_at   = 0;
        m_boot     = 1'b0;
        m_xff      = 1'b0;
        m_done     = 1'b0;
        m_ok       = 1'b0;
        m_btn_req  = 1'b0;
        m_mismatch = 0;
        q_lock     = '{1'b0, 1'b0};
        q_btn      = '{1'b0, 1'b0};
        q_boot     = '{1'b0, 1'b0};
        q_xff      = '{1'b0, 1'b0};
    endfunction

    function automatic void model_edge();
        bit lock_s, btn_s, boot_s, xff_s, req;
        if (!rst_ni) return;
        lock_s = q_lock[0];
        btn_s  = q_btn[0];
        boot_s = q_boot[0];
        xff_s  = q_xff[0];
        q_lock.push_back(clk_locked_i);          void'(q_lock.pop_front());
        q_btn.push_back(btn_rst_i);              void'(q_btn.pop_front());
        q_boot.push_back(boot_select_i);         void'(q_boot.pop_front());
        q_xff.push_back(execute_from_flash_i);   void'(q_xff.pop_front());
        req = DEB_EN ? m_btn_req : btn_s;
        if (btn_s != m_btn_req) begin
            m_mismatch++;
            if (m_mismatch == DEB) begin
                m_btn_req  = btn_s;
                m_mismatch = 0;
            end
        end else begin
            m_mismatch = 0;
        end
        m_edge++;
        if (m_mode != 0 && (!lock_s || req)) begin
            m_mode = 1;
        end else begin
            case (m_mode)
                0: m_mode = 1;
                1: begin
                    m_mode   = 2;
                    m_run_at = m_edge + HOLD;
                end
                2: if (m_edge == m_run_at) begin
                    m_mode = 3;
                    m_boot = boot_s;
                    m_xff  = xff_s;
                    m_done = 1'b0;
                    m_ok   = 1'b0;
                end
                3: if (exit_valid_i) begin
                    m_ok   = !exit_value_i;
                    m_done = 1'b1;
                    m_mode = 4;
                end
                default: ;
            endcase
        end
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic check_all();
        bit run_like;
        run_like = (m_mode == 3 || m_mode == 4);
        chk("state_o",              8'(state_o),              8'(m_mode));
        chk("soc_rst_no",           8'(soc_rst_no),           8'(run_like));
        chk("rst_led_o",            8'(rst_led_o),            8'(run_like));
        chk("boot_select_o",        8'(boot_select_o),        8'(m_boot));
        chk("execute_from_flash_o", 8'(execute_from_flash_o), 8'(m_xff));
        chk("exit_done_o",          8'(exit_done_o),          8'(m_done));
        chk("exit_ok_o",            8'(exit_ok_o),            8'(m_ok));
        chk("clk_led_o",            8'(clk_led_o),            8'((m_edge >> (LEDW - 1)) & 1));
    endtask

    task automatic step();
        @(posedge clk_i);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic measure_hold(input string tag);
        int n;
        bit seen;
        seen = 1'b0;
        n    = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            step();
            if (state_o == 3'd2) seen = 1'b1;
        end
        for (int i = 0; i < 200 && seen && soc_rst_no !== 1'b1; i++) begin
            step();
            n++;
        end
        chk(tag, 8'(n), 8'(HOLD));
    endtask

    initial begin
        int fall;
        bit found;

        rst_ni               = 1'b1;
        btn_rst_i            = 1'b0;
        clk_locked_i         = 1'b1;
        boot_select_i        = 1'b1;
        execute_from_flash_i = 1'b0;
        exit_valid_i         = 1'b0;
        exit_value_i         = 1'b0;
        #2;
        rst_ni = 1'b0;
        model_reset();
        #1;
        check_all();
        repeat (3) step();
        rst_ni = 1'b1;

        // Power-up with straps 1/0 presented during HOLD
        measure_hold("powerup_hold_len");
        chk("powerup_run", 8'(state_o), 8'd3);
        chk("powerup_boot", 8'(boot_select_o), 8'd1);
        chk("powerup_xff", 8'(execute_from_flash_o), 8'd0);

        // Strap pins wiggle in RUN
        for (int i = 0; i < 10; i++) begin
            boot_select_i        = 1'($urandom_range(0, 1));
            execute_from_flash_i = 1'($urandom_range(0, 1));
            step();
        end
        chk("straps_hold_boot", 8'(boot_select_o), 8'd1);
        chk("straps_hold_xff", 8'(execute_from_flash_o), 8'd0);

        // Lock loss for 4 cycles
        for (int i = 0; i < 4; i++) begin
            clk_locked_i = 1'b0;
            step();
            if (i == 2) begin
                chk("lockloss_rst", 8'(soc_rst_no), 8'd0);
                chk("lockloss_state", 8'(state_o), 8'd1);
            end
        end
        clk_locked_i = 1'b1;
        measure_hold("lockloss_hold_len");

        // Exit valid in the very cycle the button request reaches the FSM
        for (int i = 0; i < 25; i++) begin
            btn_rst_i    = (i < 20);
            exit_valid_i = (i == REQ_EDGE - 1);
            exit_value_i = 1'b0;
            step();
        end
        exit_valid_i = 1'b0;
        btn_rst_i    = 1'b0;
        chk("coincide_exit_done", 8'(exit_done_o), 8'd0);
        repeat (130) step();

        // Exit capture, value 0
        exit_valid_i = 1'b1;
        exit_value_i = 1'b0;
        step();
        exit_valid_i = 1'b0;
        exit_value_i = 1'b1;
        repeat (3) step();
        chk("exit0_done", 8'(exit_done_o), 8'd1);
        chk("exit0_ok", 8'(exit_ok_o), 8'd1);
        chk("exit0_state", 8'(state_o), 8'd4);

        // 10-cycle button pulse (filtered when debounce is built in)
        for (int i = 0; i < 30; i++) begin
            btn_rst_i = (i < 10);
            step();
        end
        repeat (130) step();

        // Press-to-reset latency
        fall = 0;
        for (int i = 0; i < 40; i++) begin
            btn_rst_i = (i < (DEB_EN ? 20 : 3));
            step();
            if (fall == 0 && soc_rst_no === 1'b0) fall = i + 1;
        end
        btn_rst_i = 1'b0;
        chk("press_latency", 8'(fall), 8'(REQ_EDGE));
        repeat (130) step();

        // Exit capture, value 1
        exit_valid_i = 1'b1;
        exit_value_i = 1'b1;
        step();
        exit_valid_i = 1'b0;
        repeat (2) step();
        chk("exit1_done", 8'(exit_done_o), 8'd1);
        chk("exit1_ok", 8'(exit_ok_o), 8'd0);

        // Randomized pins
        for (int i = 0; i < 600; i++) begin
            clk_locked_i         = ($urandom_range(0, 149) != 0);
            btn_rst_i            = ($urandom_range(0, 199) == 0);
            exit_valid_i         = ($urandom_range(0, 19) == 0);
            exit_value_i         = 1'($urandom_range(0, 1));
            boot_select_i        = 1'($urandom_range(0, 1));
            execute_from_flash_i = 1'($urandom_range(0, 1));
            step();
        end
        clk_locked_i = 1'b1;
        btn_rst_i    = 1'b0;
        exit_valid_i = 1'b0;
        boot_select_i        = 1'b1;
        execute_from_flash_i = 1'b1;
        repeat (40) step();

        // Asynchronous reset while the hold counter reads 30
        for (int i = 0; i < 4; i++) begin
            clk_locked_i = 1'b0;
            step();
        end
        clk_locked_i = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            step();
            if (m_mode == 2 && (m_edge - m_run_at + HOLD) == 30) found = 1'b1;
        end
        chk("hold30_reached", 8'(found), 8'd1);
        #2;
        rst_ni = 1'b0;
        model_reset();
        #1;
        check_all();
        repeat (2) step();
        rst_ni = 1'b1;
        measure_hold("after_async_hold_len");
        chk("after_async_boot", 8'(boot_select_o), 8'd1);
        chk("after_async_xff", 8'(execute_from_flash_o), 8'd1);
        repeat (5) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
